reorder_buffer: RTL and testbench

- 16-entry circular reorder buffer for the 2-wide out-of-order core.
- Allocates entries for instructions leaving rename/dispatch and records completions from the three functional units (alu1, alu2, mem).
- Retires up to two instructions per cycle in program order.
- On retire, returns the stale physical destination (rd_old) to the rename stage's free pool. The ROB index travels with each instruction through the RS as robNum.

---
 rtl/reorder_buffer_if.sv | 69 ++++++
 rtl/reorder_buffer.sv | 150 +++++++++++++++
 tb/tb_reorder_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus interface: dispatch, completion and retire signal groups.
//   master : core side (drives dispatch and completion, receives retire/status)
//   slave  : reorder buffer side
interface reorder_buffer_if #(
  parameter int unsigned ROB_SIZE_BITS = 4,
  parameter int unsigned PREG_BITS     = 6
);
  localparam int unsigned PC_W = 32;

  // Dispatch (two slots, A is older)
  logic                     disp_valid_a;
  logic                     disp_valid_b;
  logic [PC_W-1:0]          disp_pc_a;
  logic [PC_W-1:0]          disp_pc_b;
  logic [PREG_BITS-1:0]     disp_rd_a;
  logic [PREG_BITS-1:0]     disp_rd_b;
  logic [PREG_BITS-1:0]     disp_rd_old_a;
  logic [PREG_BITS-1:0]     disp_rd_old_b;
  logic                     disp_regwrite_a;
  logic                     disp_regwrite_b;
  logic [ROB_SIZE_BITS-1:0] disp_rob_num_a;
  logic [ROB_SIZE_BITS-1:0] disp_rob_num_b;
  logic                     rob_stall;

  // Completion from alu1 / alu2 / mem
  logic                     cmp_valid_0;
  logic                     cmp_valid_1;
  logic                     cmp_valid_2;
  logic [ROB_SIZE_BITS-1:0] cmp_rob_num_0;
  logic [ROB_SIZE_BITS-1:0] cmp_rob_num_1;
  logic [ROB_SIZE_BITS-1:0] cmp_rob_num_2;

  // Retire (two slots, A is older)
  logic                     ret_valid_a;
  logic                     ret_valid_b;
  logic [PC_W-1:0]          ret_pc_a;
  logic [PC_W-1:0]          ret_pc_b;
  logic [PREG_BITS-1:0]     ret_rd_a;
  logic [PREG_BITS-1:0]     ret_rd_b;
  logic                     ret_free_valid_a;
  logic                     ret_free_valid_b;
  logic [PREG_BITS-1:0]     ret_rd_old_a;
  logic [PREG_BITS-1:0]     ret_rd_old_b;
  logic                     rob_empty;

  modport master (
    output disp_valid_a, disp_valid_b, disp_pc_a, disp_pc_b,
           disp_rd_a, disp_rd_b, disp_rd_old_a, disp_rd_old_b,
           disp_regwrite_a, disp_regwrite_b,
           cmp_valid_0, cmp_valid_1, cmp_valid_2,
           cmp_rob_num_0, cmp_rob_num_1, cmp_rob_num_2,
    input  disp_rob_num_a, disp_rob_num_b, rob_stall,
           ret_valid_a, ret_valid_b, ret_pc_a, ret_pc_b, ret_rd_a, ret_rd_b,
           ret_free_valid_a, ret_free_valid_b, ret_rd_old_a, ret_rd_old_b,
           rob_empty
  );

  modport slave (
    input  disp_valid_a, disp_valid_b, disp_pc_a, disp_pc_b,
           disp_rd_a, disp_rd_b, disp_rd_old_a, disp_rd_old_b,
           disp_regwrite_a, disp_regwrite_b,
           cmp_valid_0, cmp_valid_1, cmp_valid_2,
           cmp_rob_num_0, cmp_rob_num_1, cmp_rob_num_2,
    output disp_rob_num_a, disp_rob_num_b, rob_stall,
           ret_valid_a, ret_valid_b, ret_pc_a, ret_pc_b, ret_rd_a, ret_rd_b,
           ret_free_valid_a, ret_free_valid_b, ret_rd_old_a, ret_rd_old_b,
           rob_empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer for a 2-wide out-of-order core.
// Allocates up to two entries per cycle, records completions from three
// functional units, and retires up to two instructions per cycle in order,
// returning the stale physical destination to the free pool.
// Ports:
//   clk    : core clock, rising-edge
//   reset  : synchronous, active-high
//   rob    : reorder_buffer_if.slave (dispatch / completion / retire groups)
//   perf_retired, perf_stall_cycles : only when ROB_PERF_CNT_EN is defined
// Optional feature macro: ROB_PERF_CNT_EN (performance counters).
module reorder_buffer #(
  parameter int unsigned ROB_SIZE_BITS = 4,
  parameter int unsigned PREG_BITS     = 6
) (
  input  logic              clk,
  input  logic              reset,
  reorder_buffer_if.slave   rob
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall_cycles
`endif
);
  localparam int unsigned DEPTH = 1 << ROB_SIZE_BITS;
  localparam int unsigned IDX_W = ROB_SIZE_BITS;
  localparam int unsigned PTR_W = ROB_SIZE_BITS + 1;
  localparam int unsigned CNT_W = ROB_SIZE_BITS + 1;
  localparam int unsigned PC_W  = 32;

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     done;
  logic [DEPTH-1:0]     regwrite_q;
  logic [PC_W-1:0]      pc_q     [DEPTH];
  logic [PREG_BITS-1:0] rd_q     [DEPTH];
  logic [PREG_BITS-1:0] rd_old_q [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  logic [IDX_W-1:0]     head_idx;
  logic [IDX_W-1:0]     head_idx1;
  logic [IDX_W-1:0]     tail_idx;
  logic [IDX_W-1:0]     tail_idx1;
  logic                 stall;
  logic                 disp_fire;
  logic                 disp_two;
  logic                 ret_a;
  logic                 ret_b;
  logic [1:0]           n_disp;
  logic [1:0]           n_ret;

  // Pointer decode, stall, dispatch/retire decisions and retire outputs
  always_comb begin
    head_idx  = head[IDX_W-1:0];
    head_idx1 = head_idx + IDX_W'(1);
    tail_idx  = tail[IDX_W-1:0];
    tail_idx1 = tail_idx + IDX_W'(1);

    // Registered count only; a same-cycle retire does not relieve the stall
    stall     = count > CNT_W'(DEPTH - 2);
    disp_fire = rob.disp_valid_a & ~stall;
    disp_two  = disp_fire & rob.disp_valid_b;
    n_disp    = {disp_two, disp_fire & ~disp_two};

    ret_a     = valid[head_idx] & done[head_idx];
    ret_b     = ret_a & valid[head_idx1] & done[head_idx1];
    n_ret     = {ret_b, ret_a & ~ret_b};

    rob.disp_rob_num_a   = tail_idx;
    rob.disp_rob_num_b   = tail_idx1;
    rob.rob_stall        = stall;
    // Wrap bit separates full from empty when the indices match
    rob.rob_empty        = (head == tail);

    rob.ret_valid_a      = ret_a;
    rob.ret_valid_b      = ret_b;
    rob.ret_pc_a         = ret_a ? pc_q[head_idx]     : '0;
    rob.ret_pc_b         = ret_b ? pc_q[head_idx1]    : '0;
    rob.ret_rd_a         = ret_a ? rd_q[head_idx]     : '0;
    rob.ret_rd_b         = ret_b ? rd_q[head_idx1]    : '0;
    rob.ret_rd_old_a     = ret_a ? rd_old_q[head_idx] : '0;
    rob.ret_rd_old_b     = ret_b ? rd_old_q[head_idx1]: '0;
    rob.ret_free_valid_a = ret_a & regwrite_q[head_idx];
    rob.ret_free_valid_b = ret_b & regwrite_q[head_idx1];
  end

  // Entry status and pointers; later writes win for the freshly allocated entries
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (rob.cmp_valid_0 && valid[rob.cmp_rob_num_0]) done[rob.cmp_rob_num_0] <= 1'b1;
      if (rob.cmp_valid_1 && valid[rob.cmp_rob_num_1]) done[rob.cmp_rob_num_1] <= 1'b1;
      if (rob.cmp_valid_2 && valid[rob.cmp_rob_num_2]) done[rob.cmp_rob_num_2] <= 1'b1;
      if (ret_a) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
      end
      if (ret_b) begin
        valid[head_idx1] <= 1'b0;
        done[head_idx1]  <= 1'b0;
      end
      if (disp_fire) begin
        valid[tail_idx] <= 1'b1;
        done[tail_idx]  <= 1'b0;
      end
      if (disp_two) begin
        valid[tail_idx1] <= 1'b1;
        done[tail_idx1]  <= 1'b0;
      end
      head  <= head + PTR_W'(n_ret);
      tail  <= tail + PTR_W'(n_disp);
      count <= count + CNT_W'(n_disp) - CNT_W'(n_ret);
    end
  end

  // Entry payload; only meaningful while the entry is valid, so no reset
  always_ff @(posedge clk) begin
    if (!reset && disp_fire) begin
      pc_q[tail_idx]       <= rob.disp_pc_a;
      rd_q[tail_idx]       <= rob.disp_rd_a;
      rd_old_q[tail_idx]   <= rob.disp_rd_old_a;
      regwrite_q[tail_idx] <= rob.disp_regwrite_a;
    end
    if (!reset && disp_two) begin
      pc_q[tail_idx1]       <= rob.disp_pc_b;
      rd_q[tail_idx1]       <= rob.disp_rd_b;
      rd_old_q[tail_idx1]   <= rob.disp_rd_old_b;
      regwrite_q[tail_idx1] <= rob.disp_regwrite_b;
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Retired-instruction and dispatch-stall counters, wrapping mod 2**32
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_retired      <= perf_retired + 32'(n_ret);
      perf_stall_cycles <= perf_stall_cycles + 32'(stall & rob.disp_valid_a);
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic, checked every cycle against a program-order queue model.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_SIZE_BITS(4), .PREG_BITS(6)) bus ();

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall_cycles;
`endif

  reorder_buffer #(.ROB_SIZE_BITS(4), .PREG_BITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (bus)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_retired      (perf_retired),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Model: in-flight instructions in program order
  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [5:0]  rd;
    logic [5:0]  rd_old;
    logic        rw;
    logic        done;
  } ent_t;

  ent_t        q[$];
  int          m_head;
  logic [31:0] m_perf_ret;
  logic [31:0] m_perf_stall;
  int          n_checks = 0;
  int          n_bad = 0;
  bit          chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_done_of(input int idx);
    foreach (q[i]) if (q[i].idx == idx) return q[i].done;
    return 1'b0;
  endfunction

  // Model update at each clock edge from the inputs held across it
  int   tail0, nret;
  bit   stalled;
  ent_t e;
  logic cv[3];
  int   cn[3];
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_head = 0;
      m_perf_ret = 0;
      m_perf_stall = 0;
    end else begin
      tail0   = (m_head + q.size()) % 16;
      stalled = (q.size() > 14);
      nret    = 0;
      if (q.size() > 0 && q[0].done) begin
        nret = 1;
        if (q.size() > 1 && q[1].done) nret = 2;
      end
      cv[0] = bus.cmp_valid_0; cn[0] = int'(bus.cmp_rob_num_0);
      cv[1] = bus.cmp_valid_1; cn[1] = int'(bus.cmp_rob_num_1);
      cv[2] = bus.cmp_valid_2; cn[2] = int'(bus.cmp_rob_num_2);
      for (int k = 0; k < 3; k++)
        if (cv[k])
          foreach (q[i])
            if (q[i].idx == cn[k]) begin
              e = q[i]; e.done = 1'b1; q[i] = e;
            end
      for (int r = 0; r < nret; r++) void'(q.pop_front());
      m_head = (m_head + nret) % 16;
      if (bus.disp_valid_a && !stalled) begin
        e = '{tail0, bus.disp_pc_a, bus.disp_rd_a, bus.disp_rd_old_a, bus.disp_regwrite_a, 1'b0};
        q.push_back(e);
        if (bus.disp_valid_b) begin
          e = '{(tail0 + 1) % 16, bus.disp_pc_b, bus.disp_rd_b, bus.disp_rd_old_b,
                bus.disp_regwrite_b, 1'b0};
          q.push_back(e);
        end
      end
      m_perf_ret   = m_perf_ret + 32'(nret);
      m_perf_stall = m_perf_stall + 32'(stalled && bus.disp_valid_a);
    end
  end

  // Compare process: every output against the model, mid-cycle
  int   sz;
  logic ea, eb;
  always @(negedge clk) begin
    if (chk_en) begin
      sz = q.size();
      ea = (sz > 0) && q[0].done;
      eb = 1'b0;
      if (ea && sz > 1) eb = q[1].done;
      chk("rob_num_a", 32'(bus.disp_rob_num_a), 32'((m_head + sz) % 16));
      chk("rob_num_b", 32'(bus.disp_rob_num_b), 32'((m_head + sz + 1) % 16));
      chk("rob_stall", 32'(bus.rob_stall), 32'(sz > 14));
      chk("rob_empty", 32'(bus.rob_empty), 32'(sz == 0));
      chk("ret_valid_a", 32'(bus.ret_valid_a), 32'(ea));
      chk("ret_valid_b", 32'(bus.ret_valid_b), 32'(eb));
      if (ea) begin
        chk("ret_pc_a", bus.ret_pc_a, q[0].pc);
        chk("ret_rd_a", 32'(bus.ret_rd_a), 32'(q[0].rd));
        chk("ret_rd_old_a", 32'(bus.ret_rd_old_a), 32'(q[0].rd_old));
        chk("ret_free_a", 32'(bus.ret_free_valid_a), 32'(q[0].rw));
      end else begin
        chk("ret_free_a_idle", 32'(bus.ret_free_valid_a), 32'd0);
      end
      if (eb) begin
        chk("ret_pc_b", bus.ret_pc_b, q[1].pc);
        chk("ret_rd_b", 32'(bus.ret_rd_b), 32'(q[1].rd));
        chk("ret_rd_old_b", 32'(bus.ret_rd_old_b), 32'(q[1].rd_old));
        chk("ret_free_b", 32'(bus.ret_free_valid_b), 32'(q[1].rw));
      end else begin
        chk("ret_free_b_idle", 32'(bus.ret_free_valid_b), 32'd0);
      end
`ifdef ROB_PERF_CNT_EN
      chk("perf_retired", perf_retired, m_perf_ret);
      chk("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
`endif
    end
  end

  task automatic idle();
    bus.disp_valid_a = 0; bus.disp_valid_b = 0;
    bus.disp_pc_a = 0; bus.disp_pc_b = 0;
    bus.disp_rd_a = 0; bus.disp_rd_b = 0;
    bus.disp_rd_old_a = 0; bus.disp_rd_old_b = 0;
    bus.disp_regwrite_a = 0; bus.disp_regwrite_b = 0;
    bus.cmp_valid_0 = 0; bus.cmp_valid_1 = 0; bus.cmp_valid_2 = 0;
    bus.cmp_rob_num_0 = 0; bus.cmp_rob_num_1 = 0; bus.cmp_rob_num_2 = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic disp(input logic two, input logic [31:0] pc, input logic [5:0] rd,
                      input logic [5:0] old);
    bus.disp_valid_a = 1; bus.disp_valid_b = two;
    bus.disp_pc_a = pc; bus.disp_pc_b = pc + 32'd4;
    bus.disp_rd_a = rd; bus.disp_rd_b = rd + 6'd1;
    bus.disp_rd_old_a = old; bus.disp_rd_old_b = old + 6'd1;
    bus.disp_regwrite_a = 1; bus.disp_regwrite_b = 1;
  endtask

  task automatic set_cmp(input int k, input int idx);
    case (k)
      0: begin bus.cmp_valid_0 = 1; bus.cmp_rob_num_0 = 4'(idx); end
      1: begin bus.cmp_valid_1 = 1; bus.cmp_rob_num_1 = 4'(idx); end
      default: begin bus.cmp_valid_2 = 1; bus.cmp_rob_num_2 = 4'(idx); end
    endcase
  endtask

  // Complete everything in flight and wait for it to retire (bounded)
  task automatic drain();
    int k;
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      k = 0;
      foreach (q[i])
        if (!q[i].done && k < 3) begin
          set_cmp(k, q[i].idx);
          k++;
        end
      tick();
    end
    chk("drain_empty", 32'(bus.rob_empty), 32'd1);
  endtask

  initial begin
    reset = 1;
    idle();
    repeat (2) @(negedge clk);
    reset = 0;
    chk_en = 1;

    // Reset state and first dual dispatch
    chk("rst_empty", 32'(bus.rob_empty), 32'd1);
    chk("rst_stall", 32'(bus.rob_stall), 32'd0);
    chk("rst_ret_a", 32'(bus.ret_valid_a), 32'd0);
    chk("rst_num_a", 32'(bus.disp_rob_num_a), 32'd0);
    chk("rst_num_b", 32'(bus.disp_rob_num_b), 32'd1);
    disp(1, 32'h100, 6'd33, 6'd1);
    tick();
    chk("d1_empty", 32'(bus.rob_empty), 32'd0);
    chk("d1_ret_a", 32'(bus.ret_valid_a), 32'd0);
    chk("d1_num_a", 32'(bus.disp_rob_num_a), 32'd2);
    chk("d1_model_cnt", 32'(q.size()), 32'd2);

    // Out-of-order completion, in-order dual retire
    set_cmp(0, 1);
    tick();
    chk("c1_ret_a", 32'(bus.ret_valid_a), 32'd0);
    set_cmp(0, 0);
    tick();
    chk("c0_ret_a", 32'(bus.ret_valid_a), 32'd1);
    chk("c0_ret_b", 32'(bus.ret_valid_b), 32'd1);
    chk("c0_pc_a", bus.ret_pc_a, 32'h100);
    chk("c0_rd_a", 32'(bus.ret_rd_a), 32'd33);
    chk("c0_old_a", 32'(bus.ret_rd_old_a), 32'd1);
    chk("c0_old_b", 32'(bus.ret_rd_old_b), 32'd2);
    chk("c0_free_a", 32'(bus.ret_free_valid_a), 32'd1);
    chk("c0_free_b", 32'(bus.ret_free_valid_b), 32'd1);
    tick();
    chk("c0_after_empty", 32'(bus.rob_empty), 32'd1);
    chk("c0_head2", 32'(bus.disp_rob_num_a), 32'd2);

    // Fill to the stall threshold
    for (int i = 0; i < 7; i++) begin
      disp(1, 32'h1000 + 32'(8 * i), 6'(i), 6'(i));
      tick();
    end
    chk("fill14_stall", 32'(bus.rob_stall), 32'd0);
    chk("fill14_model_cnt", 32'(q.size()), 32'd14);
    disp(0, 32'h2000, 6'd40, 6'd41);
    tick();
    chk("fill15_stall", 32'(bus.rob_stall), 32'd1);
    chk("fill15_num_a", 32'(bus.disp_rob_num_a), 32'd1);
    disp(1, 32'h3000, 6'd42, 6'd43);
    tick();
    chk("stalled_num_a", 32'(bus.disp_rob_num_a), 32'd1);
    set_cmp(0, 2);
    tick();
    chk("stall_no_credit", 32'(bus.rob_stall), 32'd1);
    tick();
    chk("stall_release", 32'(bus.rob_stall), 32'd0);
    drain();

    // Walk head to 15, then retire across the wrap
    for (int i = 0; i < 7; i++) begin
      disp(1, 32'h4000 + 32'(8 * i), 6'(i), 6'(i));
      tick();
    end
    drain();
    chk("wrap_model_head", 32'(m_head), 32'd15);
    chk("wrap_num_a", 32'(bus.disp_rob_num_a), 32'd15);
    disp(1, 32'h200, 6'd10, 6'd11);
    tick();
    set_cmp(0, 15);
    set_cmp(1, 0);
    tick();
    chk("wrap_ret_a", 32'(bus.ret_valid_a), 32'd1);
    chk("wrap_ret_b", 32'(bus.ret_valid_b), 32'd1);
    chk("wrap_pc_a", bus.ret_pc_a, 32'h200);
    chk("wrap_pc_b", bus.ret_pc_b, 32'h204);
    tick();
    chk("wrap_head1", 32'(bus.disp_rob_num_a), 32'd1);

    // Triple completion with a duplicate, plus completion to an invalid entry
    for (int i = 0; i < 3; i++) begin
      disp(1, 32'h300 + 32'(8 * i), 6'(20 + i), 6'(i));
      tick();
    end
    set_cmp(0, 3); set_cmp(1, 3); set_cmp(2, 5);
    tick();
    set_cmp(0, 9);
    tick();
    chk("tri_ret_a", 32'(bus.ret_valid_a), 32'd0);
    chk("tri_model_done3", 32'(m_done_of(3)), 32'd1);
    chk("tri_model_done5", 32'(m_done_of(5)), 32'd1);
    chk("tri_model_done4", 32'(m_done_of(4)), 32'd0);
    for (int i = 0; i < 2; i++) begin
      disp(1, 32'h400 + 32'(8 * i), 6'(30 + i), 6'(i));
      tick();
    end
    set_cmp(0, 1); set_cmp(1, 2); set_cmp(2, 4);
    tick();
    set_cmp(0, 6); set_cmp(1, 7); set_cmp(2, 8);
    tick();
    repeat (5) tick();
    chk("inv9_blocked", 32'(bus.ret_valid_a), 32'd0);
    chk("inv9_head", 32'(m_head), 32'd9);
    chk("inv9_num_a", 32'(bus.disp_rob_num_a), 32'd11);

    // Reset with six in flight, two done
    for (int i = 0; i < 2; i++) begin
      disp(1, 32'h500 + 32'(8 * i), 6'(40 + i), 6'(i));
      tick();
    end
    set_cmp(0, 12); set_cmp(1, 14);
    tick();
    chk("pre_rst_cnt", 32'(q.size()), 32'd6);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_ret_a", 32'(bus.ret_valid_a), 32'd0);
    chk("mid_rst_ret_b", 32'(bus.ret_valid_b), 32'd0);
    chk("mid_rst_empty", 32'(bus.rob_empty), 32'd1);
    chk("mid_rst_num_a", 32'(bus.disp_rob_num_a), 32'd0);
    disp(0, 32'h600, 6'd50, 6'd51);
    tick();
    chk("post_rst_num_a", 32'(bus.disp_rob_num_a), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      bus.disp_valid_a = ($urandom_range(0, 9) < 7);
      bus.disp_valid_b = $urandom_range(0, 1);
      bus.disp_pc_a = $urandom; bus.disp_pc_b = $urandom;
      bus.disp_rd_a = 6'($urandom); bus.disp_rd_b = 6'($urandom);
      bus.disp_rd_old_a = 6'($urandom); bus.disp_rd_old_b = 6'($urandom);
      bus.disp_regwrite_a = $urandom_range(0, 1);
      bus.disp_regwrite_b = $urandom_range(0, 1);
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 9) < 5) begin
          if (q.size() > 0 && $urandom_range(0, 7) != 0)
            set_cmp(k, q[$urandom_range(0, q.size() - 1)].idx);
          else
            set_cmp(k, int'($urandom_range(0, 15)));
        end
      tick();
      reset = 0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
